inst_rom: RTL
=============

# inst_rom

Instruction-memory responder for the CPU's fetch port: it answers `ce`/`addr` with the instruction word in the same cycle, so the IF/ID register captures it on the next edge alongside the PC. It also contains a byte-serial program loader (valid/ready handshake) that assembles big-endian words and writes them sequentially from word 0. It sits outside the CPU core, between the core's `ram_ce`/`ram_addr`/`ram_data` pins and the host/bench that supplies the program image.

## Interface
- `DEPTH_LOG2`, 10, log2 of memory depth in 32-bit words (DEPTH = 2^DEPTH_LOG2).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-low (asserted when 0).
- `ce`  in  1  fetch enable from the core.
- `addr`  in  32  fetch byte address from the core.
- `data`  out  32  instruction word to the core.
- `ld_start`  in  1  one-cycle pulse: begin (or restart) a program load.
- `ld_valid`  in  1  `ld_byte` is valid.
- `ld_byte`  in  8  program byte, big-endian order within each word.
- `ld_last`  in  1  qualifies the final byte of the image (sampled with `ld_valid`).
- `ld_ready`  out  1  loader accepts a byte this cycle.
- `ld_done`  out  1  a load has completed; memory is servable.
- `ld_full`  out  1  the load ended because all DEPTH words were written.
- `word_count`  out  DEPTH_LOG2+1  words written by the current or last load.

## Operation
- States: IDLE, LOAD, DONE. Reset -> IDLE.
- Byte accept = `ld_valid && ld_ready` at a rising edge. `ld_ready` = 1 only in LOAD.
- IDLE: `ld_start` -> LOAD. Clears the byte counter (2 bits), the assembly register, `word_count`, `ld_done` and `ld_full`.
- LOAD:
  - Each accepted byte shifts into the assembly register: the first byte of a word goes to [31:24] and the fourth to [7:0].
  - On the 4th accepted byte, write the assembled word to mem[`word_count`] and increment `word_count`.
  - Accepted byte with `ld_last`=1:
    - Write the partial word, if any, with the unfilled low bytes zero. If the word is already complete, write only that word.
    - Go to DONE.
  - Write that brings `word_count` to DEPTH: go to DONE with `ld_full`=1. No further bytes are accepted, and a coincident `ld_last` is irrelevant.
  - `ld_start` in LOAD restarts: counters are cleared and the state stays LOAD. `ld_start` has priority over a byte in the same cycle; that byte is dropped.
  - `ld_last` on an empty image (first byte) writes one word {byte,24'h0}, giving `word_count`=1.
- DONE: `ld_done`=1. `ld_start` -> LOAD, which clears `ld_done`/`ld_full`.
- Fetch path (combinational):
  - `data` = mem[`addr`[DEPTH_LOG2+1:2]] when `ce`=1, state != LOAD, and `addr`[31:DEPTH_LOG2+2]==0.
  - Otherwise `data`=32'h0.
  - `addr`[1:0] is ignored.
- Memory contents are not cleared by reset. A reset mid-load aborts the load: words already written remain, the state goes to IDLE, and `word_count`=0.

## Timing
- Reset values: `ld_ready`=0, `ld_done`=0, `ld_full`=0, `word_count`=0, state IDLE. `data` is combinational and is 0 while `ce`=0.
- Fetch latency is 0 cycles: `data` is valid in the same cycle as `addr`/`ce`, and the core registers it at the next edge.
- Word write takes effect at the edge that accepts the 4th (or last) byte. `word_count` updates at the same edge.
- Throughput is 1 byte/cycle, so a full word takes 4 cycles.
- LOAD->DONE takes effect at the edge that accepts the last byte or fills memory. `ld_ready` is 0 and `ld_done` is 1 from the following cycle, and fetch is live in that cycle.
- `ld_start`->LOAD: `ld_ready`=1 in the cycle after the pulse.

## Test plan
- Reset, then `ce`=1, `addr`=0 -> `data`=0 only if `ce`=0; with `ce`=1 in IDLE, `data` = mem[0]. Check `ld_ready`/`ld_done`/`ld_full`/`word_count` are all 0 while `rst`=0, including asynchronously mid-cycle.
- `ld_start`, then bytes 8'h34,8'h01,8'h00,8'h0A (last on the 4th) -> `word_count`=1, `ld_done`=1; fetch `addr`=32'h0 and 32'h3 -> both give 32'h3401000A.
- Load 6 bytes 11,22,33,44,55,66 with last on 66 -> mem[1]=32'h55660000, `word_count`=2. Fetch `addr`=4 -> 32'h55660000. `addr`=32'h0001_0000 (out of range at DEPTH_LOG2=10) -> 0.
- Gapped `ld_valid` (1 byte every 3 cycles) with `ld_start` re-pulsed after 2 bytes -> restart: the next 4 bytes form mem[0], and `word_count` counts only post-restart words.
- DEPTH_LOG2=2: stream 20 bytes with no `ld_last` -> after 16 bytes `ld_full`=1, `ld_done`=1, `ld_ready`=0, `word_count`=4; the remaining bytes are not accepted.
- Drop `rst` after 2 words of a load -> IDLE, `word_count`=0, `ld_ready`=0. Fetch of words 0 and 1 returns the written values.

Source files
------------

// File: rtl/inst_rom.sv
// Instruction ROM for the CPU fetch port, with a byte-serial program loader.
// Fetch is combinational, so the word is ready in the same cycle as addr/ce.
// The loader packs bytes big-endian into 32-bit words and writes them to
// memory in order, starting at word 0.
module inst_rom #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           data,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  ld_full,
    output logic [DEPTH_LOG2:0]   word_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [31:0]         asm_q, asm_d;
    logic [DEPTH_LOG2:0] wcnt_q, wcnt_d;
    logic                full_q, full_d;

    logic [31:0]           mem [DEPTH];
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    logic [31:0]           asm_ins;
    logic [DEPTH_LOG2:0]   wcnt_inc;
    logic                  fetch_hit;
    logic                  unused_addr;

    // Increment of the word counter; its MSB flags that memory is now full.
    assign wcnt_inc = wcnt_q + {{DEPTH_LOG2{1'b0}}, 1'b1};

    // Drop the incoming byte into its big-endian lane of the current word.
    always_comb begin
        asm_ins = asm_q;
        case (bcnt_q)
            2'd0:    asm_ins[31:24] = ld_byte;
            2'd1:    asm_ins[23:16] = ld_byte;
            2'd2:    asm_ins[15:8]  = ld_byte;
            default: asm_ins[7:0]   = ld_byte;
        endcase
    end

    // Loader next-state: byte accept, word commit, restart and completion.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        wcnt_d    = wcnt_q;
        full_d    = full_q;
        mem_we    = 1'b0;
        mem_waddr = wcnt_q[DEPTH_LOG2-1:0];
        mem_wdata = asm_ins;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ld_start) begin
                    state_d = S_LOAD;
                    bcnt_d  = 2'd0;
                    asm_d   = 32'h0;
                    wcnt_d  = '0;
                    full_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (ld_start) begin
                    // Restart wins over a byte presented in the same cycle.
                    bcnt_d = 2'd0;
                    asm_d  = 32'h0;
                    wcnt_d = '0;
                    full_d = 1'b0;
                end else if (ld_valid) begin
                    if (bcnt_q == 2'd3 || ld_last) begin
                        // Unfilled low lanes are already zero because the
                        // assembly register is cleared after every commit.
                        mem_we = 1'b1;
                        wcnt_d = wcnt_inc;
                        bcnt_d = 2'd0;
                        asm_d  = 32'h0;
                        if (wcnt_inc[DEPTH_LOG2]) begin
                            state_d = S_DONE;
                            full_d  = 1'b1;
                        end else if (ld_last) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                        asm_d  = asm_ins;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; a reset aborts any load in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            bcnt_q  <= 2'd0;
            asm_q   <= 32'h0;
            wcnt_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            wcnt_q  <= wcnt_d;
            full_q  <= full_d;
        end
    end

    // Program memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Fetch is blocked while a load is in progress and for addresses past the end.
    assign fetch_hit   = ce && (state_q != S_LOAD) && (addr[31:DEPTH_LOG2+2] == '0);
    assign data        = fetch_hit ? mem[addr[DEPTH_LOG2+1:2]] : 32'h0;
    assign unused_addr = ^addr[1:0];

    assign ld_ready   = (state_q == S_LOAD);
    assign ld_done    = (state_q == S_DONE);
    assign ld_full    = full_q;
    assign word_count = wcnt_q;

endmodule
